// File: rtl/mips_rf_pkg.sv
// Shared constants and one-hot helpers for the MIPS register file.
package mips_rf_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int RADDR_W  = 5;

    function automatic logic onehot_valid(input logic [NUM_REGS-1:0] vec);
        return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
    endfunction

    // Only meaningful when onehot_valid(vec) is true.
    function automatic logic [RADDR_W-1:0] onehot_index(input logic [NUM_REGS-1:0] vec);
        logic [RADDR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (vec[i]) idx = idx | RADDR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rf_reg_cell.sv
// Single register-file word: async active-low clear, synchronous load.
module rf_reg_cell #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mips_regfile_onehot.sv
// 32x32 MIPS register file driven by a one-hot write-enable vector,
// with optional write-to-read bypass and malformed-vector detection.
module mips_regfile_onehot #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REGS-1:0]              write_en,
    input  logic [DATA_W-1:0]                write_data,
    input  logic [mips_rf_pkg::RADDR_W-1:0]  read_reg1,
    input  logic [mips_rf_pkg::RADDR_W-1:0]  read_reg2,
    output logic [DATA_W-1:0]                read_data1,
    output logic [DATA_W-1:0]                read_data2,
    output logic                             onehot_err,
    output logic [15:0]                      write_count
);

    import mips_rf_pkg::*;

    logic [NUM_REGS-1:0]             wm;
    logic                            wr_valid;
    logic                            wr_multi;
    logic [RADDR_W-1:0]              wr_idx;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    // Bit 0 targets $zero, so it never counts toward a write or an error.
    assign wm       = write_en & ~NUM_REGS'(1);
    assign wr_valid = onehot_valid(wm);
    assign wr_multi = (wm != '0) && !wr_valid;
    assign wr_idx   = onehot_index(wm);

    assign regs[0] = '0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cell
        rf_reg_cell #(
            .DATA_W (DATA_W)
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (wm[g] & wr_valid),
            .d     (write_data),
            .q     (regs[g])
        );
    end

    always_comb begin
        read_data1 = regs[read_reg1];
        read_data2 = regs[read_reg2];
        // wr_idx is never 0 when wr_valid, so $zero stays hardwired.
        if (BYPASS && wr_valid) begin
            if (wr_idx == read_reg1) read_data1 = write_data;
            if (wr_idx == read_reg2) read_data2 = write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot_err  <= 1'b0;
            write_count <= '0;
        end else begin
            if (wr_multi) onehot_err <= 1'b1;
            if (wr_valid) write_count <= write_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mips_regfile_onehot.sv
// Directed bench for mips_regfile_onehot, bypass and non-bypass variants side by side.
module tb_mips_regfile_onehot;

    logic        clk;
    logic        rst_n;
    logic [31:0] write_en;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        err_b, err_n;
    logic [15:0] cnt_b, cnt_n;

    int n_checks = 0;
    int n_fail   = 0;

    mips_regfile_onehot #(.DATA_W(32), .NUM_REGS(32), .BYPASS(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_data(write_data),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1_b), .read_data2(rd2_b),
        .onehot_err(err_b), .write_count(cnt_b)
    );

    mips_regfile_onehot #(.DATA_W(32), .NUM_REGS(32), .BYPASS(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_data(write_data),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1_n), .read_data2(rd2_n),
        .onehot_err(err_n), .write_count(cnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; write_en = '0; write_data = '0;
        read_reg1 = 5'd5; read_reg2 = 5'd31;
        tick(); tick();
        n_checks++;
        if (rd1_b !== 32'h0 || rd2_b !== 32'h0 || rd1_n !== 32'h0 || rd2_n !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_reads: got %h %h %h %h, want all 0", rd1_b, rd2_b, rd1_n, rd2_n);
        end
        n_checks++;
        if (err_b !== 1'b0 || err_n !== 1'b0 || cnt_b !== 16'h0 || cnt_n !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_status: got err %b/%b cnt %h/%h, want 0/0 0000/0000", err_b, err_n, cnt_b, cnt_n);
        end
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_write();
        write_en = 32'h0000_0020; write_data = 32'hDEAD_BEEF;
        tick();
        write_en = '0; read_reg1 = 5'd5;
        #1;
        n_checks++;
        if (rd1_b !== 32'hDEAD_BEEF || rd1_n !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL basic_write_data: got %h/%h, want deadbeef", rd1_b, rd1_n);
        end
        n_checks++;
        if (cnt_b !== 16'd1 || cnt_n !== 16'd1) begin
            n_fail++;
            $display("FAIL basic_write_count: got %0d/%0d, want 1", cnt_b, cnt_n);
        end
    endtask

    task automatic test_zero_write();
        write_en = 32'h0000_0001; write_data = 32'h1234_5678;
        read_reg1 = 5'd0; read_reg2 = 5'd0;
        #1;
        n_checks++;
        if (rd1_b !== 32'h0 || rd2_b !== 32'h0 || rd1_n !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_bypass: got %h %h %h, want 0", rd1_b, rd2_b, rd1_n);
        end
        tick();
        write_en = '0;
        #1;
        n_checks++;
        if (rd1_b !== 32'h0 || rd2_n !== 32'h0 || cnt_b !== 16'd1 || err_b !== 1'b0 || err_n !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_write: got rd %h/%h cnt %0d err %b/%b, want 0/0 1 0/0",
                     rd1_b, rd2_n, cnt_b, err_b, err_n);
        end
    endtask

    task automatic test_multi_hot();
        write_en = 32'h0000_0006; write_data = 32'hFFFF_FFFF;
        read_reg1 = 5'd1; read_reg2 = 5'd2;
        #1;
        n_checks++;
        if (rd1_b !== 32'h0 || rd2_b !== 32'h0) begin
            n_fail++;
            $display("FAIL multi_no_bypass: got %h %h, want 0 0", rd1_b, rd2_b);
        end
        tick();
        write_en = '0;
        #1;
        n_checks++;
        if (rd1_n !== 32'h0 || rd2_n !== 32'h0 || rd1_b !== 32'h0 || rd2_b !== 32'h0) begin
            n_fail++;
            $display("FAIL multi_no_write: got %h %h %h %h, want 0", rd1_n, rd2_n, rd1_b, rd2_b);
        end
        n_checks++;
        if (err_b !== 1'b1 || err_n !== 1'b1 || cnt_n !== 16'd1) begin
            n_fail++;
            $display("FAIL multi_err: got err %b/%b cnt %0d, want 1/1 1", err_b, err_n, cnt_n);
        end
        write_en = 32'h0000_0008; write_data = 32'h0000_0011;
        tick();
        write_en = '0; read_reg1 = 5'd3;
        #1;
        n_checks++;
        if (err_b !== 1'b1 || err_n !== 1'b1 || cnt_b !== 16'd2 || rd1_n !== 32'h11) begin
            n_fail++;
            $display("FAIL multi_sticky: got err %b/%b cnt %0d rd %h, want 1/1 2 00000011",
                     err_b, err_n, cnt_b, rd1_n);
        end
    endtask

    task automatic test_bypass();
        read_reg1 = 5'd10; read_reg2 = 5'd10;
        write_en = 32'h0000_0400; write_data = 32'hA5A5_A5A5;
        #1;
        n_checks++;
        if (rd1_b !== 32'hA5A5_A5A5 || rd2_b !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL bypass_on: got %h %h, want a5a5a5a5", rd1_b, rd2_b);
        end
        n_checks++;
        if (rd1_n !== 32'h0 || rd2_n !== 32'h0) begin
            n_fail++;
            $display("FAIL bypass_off_before: got %h %h, want 0", rd1_n, rd2_n);
        end
        tick();
        write_en = '0;
        #1;
        n_checks++;
        if (rd1_n !== 32'hA5A5_A5A5 || rd2_n !== 32'hA5A5_A5A5 || rd2_b !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL bypass_off_after: got %h %h %h, want a5a5a5a5", rd1_n, rd2_n, rd2_b);
        end
        read_reg1 = 5'd5; read_reg2 = 5'd10;
        #1;
        n_checks++;
        if (rd1_b !== 32'hDEAD_BEEF || rd2_b !== 32'hA5A5_A5A5 || cnt_b !== 16'd3) begin
            n_fail++;
            $display("FAIL two_ports: got %h %h cnt %0d, want deadbeef a5a5a5a5 3", rd1_b, rd2_b, cnt_b);
        end
    endtask

    task automatic test_wrap();
        // Count is 3; 65532 more writes reach 0xFFFF.
        write_en = 32'h0000_0080;
        for (int i = 0; i < 65532; i++) begin
            write_data = i;
            tick();
        end
        write_en = '0; read_reg1 = 5'd7;
        #1;
        n_checks++;
        if (cnt_b !== 16'hFFFF || cnt_n !== 16'hFFFF || rd1_n !== 32'd65531) begin
            n_fail++;
            $display("FAIL wrap_ffff: got cnt %h/%h rd %0d, want ffff 65531", cnt_b, cnt_n, rd1_n);
        end
        write_en = 32'h8000_0000; write_data = 32'hCAFE_0001;
        tick();
        write_en = '0; read_reg2 = 5'd31;
        #1;
        n_checks++;
        if (cnt_b !== 16'h0000 || cnt_n !== 16'h0000 || rd2_n !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL wrap_zero: got cnt %h/%h rd %h, want 0000 cafe0001", cnt_b, cnt_n, rd2_n);
        end
    endtask

    task automatic test_async_reset();
        read_reg1 = 5'd5; read_reg2 = 5'd10;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (rd1_b !== 32'h0 || rd2_b !== 32'h0 || rd1_n !== 32'h0 || rd2_n !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_reads: got %h %h %h %h, want 0", rd1_b, rd2_b, rd1_n, rd2_n);
        end
        n_checks++;
        if (err_b !== 1'b0 || err_n !== 1'b0 || cnt_b !== 16'h0 || cnt_n !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset_status: got err %b/%b cnt %h/%h, want 0 0", err_b, err_n, cnt_b, cnt_n);
        end
        tick();
        #2 rst_n = 1'b1;
        write_en = 32'h0000_0020; write_data = 32'h0000_0055;
        #1;
        n_checks++;
        if (rd1_n !== 32'h0 || cnt_n !== 16'h0) begin
            n_fail++;
            $display("FAIL release_no_write: got rd %h cnt %0d, want 0 0", rd1_n, cnt_n);
        end
        tick();
        write_en = '0;
        #1;
        n_checks++;
        if (rd1_n !== 32'h55 || cnt_n !== 16'd1 || cnt_b !== 16'd1) begin
            n_fail++;
            $display("FAIL release_write: got rd %h cnt %0d/%0d, want 55 1", rd1_n, cnt_n, cnt_b);
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_zero_write();
        test_multi_hot();
        test_bypass();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
